// File: rtl/dff_pkg.sv
// dff_pkg: shared defaults and update-source naming for the D flip-flop family
package dff_pkg;

    localparam int   DEFAULT_WIDTH     = 1;
    localparam logic DEFAULT_RESET_BIT = 1'b0;
    localparam logic DEFAULT_SET_BIT   = 1'b1;

    typedef enum logic [1:0] {
        SRC_DATA,
        SRC_RESET,
        SRC_SET
    } src_e;

endpackage

// File: rtl/dff_bit.sv
// dff_bit: single-bit flop with synchronous reset over synchronous set over data
module dff_bit
    import dff_pkg::*;
#(
    parameter logic RESET_BIT = DEFAULT_RESET_BIT,
    parameter logic SET_BIT   = DEFAULT_SET_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic d,
    output logic q
);

    // reset beats set, set beats data, all on the rising edge only
    always_ff @(posedge clk) begin
        if (rst) q <= RESET_BIT;
        else if (set) q <= SET_BIT;
        else q <= d;
    end

endmodule

// File: rtl/d_flip_flop.sv
// d_flip_flop: WIDTH-bit D register with sync reset/set values and complement output
module d_flip_flop
    import dff_pkg::*;
#(
    parameter int                 WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}},
    parameter logic [WIDTH-1:0]   SET_VALUE   = {WIDTH{DEFAULT_SET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit #(
            .RESET_BIT(RESET_VALUE[i]),
            .SET_BIT  (SET_VALUE[i])
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .set(set),
            .d  (D[i]),
            .q  (Q[i])
        );
    end

    assign Qn = ~Q;

    src_e src_q;
    logic chk_q;

    // remember which source drove the last edge so the result can be checked one edge later
    always_ff @(posedge clk) begin
        src_q <= rst ? SRC_RESET : (set ? SRC_SET : SRC_DATA);
        chk_q <= 1'b1;
    end

    a_qn_complement: assert property (@(posedge clk) Qn == ~Q);
    a_reset_value:   assert property (@(posedge clk) chk_q && src_q == SRC_RESET |-> Q == RESET_VALUE);
    a_set_value:     assert property (@(posedge clk) chk_q && src_q == SRC_SET |-> Q == SET_VALUE);

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of a 1-bit and an 8-bit d_flip_flop
module tb_d_flip_flop;

    logic       clk = 1'b0;
    logic       rst1, set1, d1;
    logic       q1, qn1;
    logic       rst8, set8;
    logic [7:0] d8, q8, qn8;
    int         total = 0;
    int         bad = 0;

    always #20 clk = ~clk;

    d_flip_flop u_dut1 (
        .clk(clk), .rst(rst1), .set(set1), .D(d1), .Q(q1), .Qn(qn1)
    );

    d_flip_flop #(
        .WIDTH(8), .RESET_VALUE(8'h00), .SET_VALUE(8'hA5)
    ) u_dut8 (
        .clk(clk), .rst(rst8), .set(set8), .D(d8), .Q(q8), .Qn(qn8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; set1 = 1'b0; d1 = 1'b1;
        rst8 = 1'b1; set8 = 1'b0; d8 = 8'hFF;
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL reset_q got=%b want=0", q1); end
        total++; if (qn1 !== 1'b1) begin bad++; $display("FAIL reset_qn got=%b want=1", qn1); end
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL reset_q8 got=%h want=00", q8); end
        total++; if (qn8 !== 8'hFF) begin bad++; $display("FAIL reset_qn8 got=%h want=ff", qn8); end
        for (int i = 0; i < 20; i++) begin
            #3 d1 = ~d1;
            total++; if (q1 !== 1'b0) begin bad++; $display("FAIL reset_hold step=%0d got=%b want=0", i, q1); end
        end
    endtask

    task automatic test_capture();
        tick();
        rst1 = 1'b0; set1 = 1'b0; d1 = 1'b1;
        tick();
        d1 = 1'b0;
        total++; if (q1 !== 1'b1) begin bad++; $display("FAIL capture_one got=%b want=1", q1); end
        #15;
        total++; if (q1 !== 1'b1) begin bad++; $display("FAIL capture_hold got=%b want=1", q1); end
        total++; if (qn1 !== 1'b0) begin bad++; $display("FAIL capture_qn got=%b want=0", qn1); end
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL capture_zero got=%b want=0", q1); end
    endtask

    task automatic test_glitch();
        #5 d1 = 1'b1;
        #5 d1 = 1'b0;
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL glitch_low got=%b want=0", q1); end
        d1 = 1'b1;
        tick();
        #5 d1 = 1'b0;
        #5 d1 = 1'b1;
        tick();
        total++; if (q1 !== 1'b1) begin bad++; $display("FAIL glitch_high got=%b want=1", q1); end
    endtask

    task automatic test_set();
        set1 = 1'b1; d1 = 1'b0;
        tick();
        total++; if (q1 !== 1'b1) begin bad++; $display("FAIL set_q got=%b want=1", q1); end
        total++; if (qn1 !== 1'b0) begin bad++; $display("FAIL set_qn got=%b want=0", qn1); end
        set1 = 1'b0;
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL set_release got=%b want=0", q1); end
    endtask

    task automatic test_priority();
        d1 = 1'b1;
        tick();
        rst1 = 1'b1; set1 = 1'b1; d1 = 1'b1;
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL prio_rst_over_set got=%b want=0", q1); end
        total++; if (qn1 !== 1'b1) begin bad++; $display("FAIL prio_qn got=%b want=1", qn1); end
        rst1 = 1'b0; d1 = 1'b0;
        tick();
        total++; if (q1 !== 1'b1) begin bad++; $display("FAIL prio_set_after got=%b want=1", q1); end
        set1 = 1'b0;
        tick();
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL prio_data_after got=%b want=0", q1); end
    endtask

    task automatic test_wide();
        rst8 = 1'b0; set8 = 1'b0; d8 = 8'h3C;
        tick();
        total++; if (q8 !== 8'h3C) begin bad++; $display("FAIL wide_capture got=%h want=3c", q8); end
        total++; if (qn8 !== 8'hC3) begin bad++; $display("FAIL wide_capture_qn got=%h want=c3", qn8); end
        set8 = 1'b1;
        tick();
        total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL wide_set got=%h want=a5", q8); end
        total++; if (qn8 !== 8'h5A) begin bad++; $display("FAIL wide_set_qn got=%h want=5a", qn8); end
        rst8 = 1'b1;
        tick();
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL wide_reset got=%h want=00", q8); end
        total++; if (qn8 !== 8'hFF) begin bad++; $display("FAIL wide_reset_qn got=%h want=ff", qn8); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [4];
        vec = '{8'h11, 8'hE2, 8'h00, 8'h7F};
        rst8 = 1'b0; set8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d8 = vec[i];
            tick();
            total++; if (q8 !== vec[i]) begin bad++; $display("FAIL b2b_q idx=%0d got=%h want=%h", i, q8, vec[i]); end
            total++; if (qn8 !== ~vec[i]) begin bad++; $display("FAIL b2b_qn idx=%0d got=%h want=%h", i, qn8, ~vec[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_glitch();
        test_set();
        test_priority();
        test_wide();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Parameterised edge-triggered D-type storage register with synchronous reset and synchronous set.
- Generic state element used wherever a registered, initialisable bit or bus is needed: pipeline stages, status flags, control latches.
- Default configuration (WIDTH=1) is a single D flip-flop.

Parameters:
- WIDTH, 1, number of stored bits in D/Q/Qn.
- RESET_VALUE, all zeros ({WIDTH{1'b0}}), value loaded into Q when rst is sampled high.
- SET_VALUE, all ones ({WIDTH{1'b1}}), value loaded into Q when set is sampled high and rst is low.

Ports:
- clk  input  1  clock; all state changes on rising edge only.
- rst  input  1  synchronous reset, active-high.
- set  input  1  synchronous set, active-high.
- D  input  WIDTH  data input, sampled on rising clk edge.
- Q  output  WIDTH  registered data output.
- Qn  output  WIDTH  bitwise complement of Q, always equal to ~Q.

Behaviour:
- One clock; reset is synchronous and active-high (port rst, clock port clk).
- All updates occur only at the rising edge of clk. No asynchronous paths.
- Priority at each rising edge, highest first:
  - rst=1: Q <= RESET_VALUE.
  - else set=1: Q <= SET_VALUE.
  - else: Q <= D.
- Simultaneous rst=1 and set=1: reset wins, Q <= RESET_VALUE.
- Latency: D sampled at edge N appears on Q immediately after edge N (1-cycle register). Q holds between edges.
- Glitches or pulses on D, rst or set that begin and end between two rising edges have no effect.
- Qn is combinational ~Q; no extra latency; Qn = ~RESET_VALUE while in reset.
- Power-up, before the first reset edge: Q undefined (X in simulation). Implementation must not use an initial block to hide this.
- Reset mid-operation: a single edge with rst=1 clears Q regardless of D or set. The following edge with rst=0 resumes normal capture or set.
- Set released: the next edge with set=0 and rst=0 captures D again.
- Width rules: D, Q, Qn all exactly WIDTH bits. RESET_VALUE and SET_VALUE are truncated or zero-extended to WIDTH.

Decomposition:
- Shared package dff_pkg:
  - default WIDTH constant;
  - default RESET_VALUE and SET_VALUE constants;
  - an enum naming the update source (SRC_RESET, SRC_SET, SRC_DATA), used by assertions/coverage.
- One natural sub-module: dff_bit, a single-bit flop with rst/set priority.
- d_flip_flop generates WIDTH instances of dff_bit, passing per-bit reset/set values.
- Include immediate/concurrent assertions:
  - Qn == ~Q at all times;
  - after an edge with rst=1, Q == RESET_VALUE;
  - after an edge with rst=0 and set=1, Q == SET_VALUE.

Test Plan:
- Reset: clk period 40, rst=1, D=1, set=0 across edge at t=20 -> Q=0, Qn=1 after edge. Hold rst=1 with D toggling every 3 time units -> Q stays 0.
- Capture: rst=0, set=0, D=1 before edge, D=0 after edge -> Q=1 after edge and stays 1 until next edge. D=0 at next edge -> Q=0.
- Mid-cycle glitch: D pulses 0->1->0 entirely between two edges -> Q unchanged.
- Set: rst=0, set=1, D=0 at edge -> Q=1. Next edge set=0, D=0 -> Q=0.
- Priority: rst=1, set=1, D=1 at edge -> Q=0. Then rst=0, set=1 -> Q=1 at next edge.
- WIDTH=8, RESET_VALUE=8'h00, SET_VALUE=8'hA5:
  - D=8'h3C -> Q=8'h3C, Qn=8'hC3;
  - set=1 -> Q=8'hA5;
  - rst=1 -> Q=8'h00.
